// File: rtl/proc_pkg.sv
`default_nettype none
// Shared pipeline definitions: memory-arbiter state encoding, bus owner IDs, word width.
// Revision: 1.0
package proc_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ERR   = 2'd3
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// arb_starve_ctr: saturating 4-bit count of grants lost by fetch, with limit compare.
// Revision: 1.0
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != 4'hF) begin
      count <= count + 4'd1;
    end
  end

  assign hit = (count >= 4'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one multi-cycle single-port memory between fetch (I) and data (D) ports.
// Revision: 1.0
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W       = WORD_W,
  parameter int DATA_W       = WORD_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  arb_state_t      state, state_nx;
  logic            owner;
  logic            cancel_pend;
  logic            starve_hit;
  logic [TO_W-1:0] to_cnt;
  logic            i_elig, d_elig;
  logic            grant_i, grant_d, accept, complete, expire;

  // The done pulse masks the requester's stale level request in its completion cycle.
  assign i_elig = i_req & ~i_done & ~i_cancel;
  assign d_elig = d_req & ~d_done;

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grant_d & i_elig),
    .clr (grant_i),
    .hit (starve_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    mem_en   = 1'b0;
    i_stall  = i_req & ~i_done & ~i_cancel;
    d_stall  = d_req & ~d_done;
    case (state)
      ARB_IDLE: begin
        if (i_elig && (!d_elig || starve_hit)) grant_i = 1'b1;
        else if (d_elig)                       grant_d = 1'b1;
        if (grant_i || grant_d) state_nx = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_en = 1'b1;
        if (!mem_stall) begin
          accept   = 1'b1;
          state_nx = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // A completion on the final allowed cycle still counts as a completion.
        if (mem_done) begin
          complete = 1'b1;
          state_nx = ARB_IDLE;
        end else if (to_cnt == TO_LAST) begin
          expire   = 1'b1;
          state_nx = ARB_ERR;
        end
      end
      ARB_ERR: begin
        i_stall = 1'b1;
        d_stall = 1'b1;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= OWNER_I;
      mem_addr    <= '0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      to_cnt      <= '0;
      cancel_pend <= 1'b0;
      err         <= 1'b0;
      i_done      <= 1'b0;
      i_rdata     <= '0;
      d_done      <= 1'b0;
      d_rdata     <= '0;
    end else begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;

      if (grant_i) begin
        owner     <= OWNER_I;
        mem_addr  <= i_addr;
        mem_wr    <= 1'b0;
        mem_wdata <= '0;
      end else if (grant_d) begin
        owner     <= OWNER_D;
        mem_addr  <= d_addr;
        mem_wr    <= d_wr;
        mem_wdata <= d_wdata;
      end

      if (accept)                 to_cnt <= '0;
      else if (state == ARB_WAIT) to_cnt <= to_cnt + TO_W'(1);

      if (complete) begin
        cancel_pend <= 1'b0;
      end else if (i_cancel && owner == OWNER_I &&
                   (state == ARB_ISSUE || state == ARB_WAIT)) begin
        cancel_pend <= 1'b1;
      end

      // A squashed fetch still drains the memory but never reports completion.
      if (complete) begin
        if (owner == OWNER_I) begin
          i_done  <= ~(cancel_pend | i_cancel);
          i_rdata <= (cancel_pend | i_cancel) ? '0 : mem_rdata;
        end else begin
          d_done  <= 1'b1;
          d_rdata <= mem_wr ? '0 : mem_rdata;
        end
      end

      if (expire) err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written corner sequences.
// Revision: 1.0
module tb_mem_arbiter;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_cancel, i_done, i_stall;
  logic [15:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_done, d_stall;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_wr, mem_stall, mem_done, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
    .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err)
  );

  typedef struct packed {
    logic i_req; logic [15:0] i_addr; logic i_cancel;
    logic d_req; logic d_wr; logic [15:0] d_addr; logic [15:0] d_wdata;
    logic mem_stall; logic mem_done; logic [15:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic mem_en; logic mem_wr; logic [15:0] mem_addr; logic [15:0] mem_wdata;
    logic i_done; logic [15:0] i_rdata; logic i_stall;
    logic d_done; logic [15:0] d_rdata; logic d_stall; logic err;
  } out_t;

  typedef struct packed { in_t in; out_t exp; } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  int n_run  = 0;
  int n_fail = 0;

  function automatic in_t vi(input logic ir, input logic [15:0] ia, input logic ic,
                             input logic dr, input logic dw, input logic [15:0] da,
                             input logic [15:0] dwd, input logic ms, input logic md,
                             input logic [15:0] mr);
    in_t v;
    v.i_req = ir; v.i_addr = ia; v.i_cancel = ic;
    v.d_req = dr; v.d_wr = dw; v.d_addr = da; v.d_wdata = dwd;
    v.mem_stall = ms; v.mem_done = md; v.mem_rdata = mr;
    return v;
  endfunction

  function automatic out_t vo(input logic en, input logic wr, input logic [15:0] ad,
                              input logic [15:0] wd, input logic idn, input logic [15:0] ird,
                              input logic ist, input logic ddn, input logic [15:0] drd,
                              input logic dst);
    out_t o;
    o.mem_en = en; o.mem_wr = wr; o.mem_addr = ad; o.mem_wdata = wd;
    o.i_done = idn; o.i_rdata = ird; o.i_stall = ist;
    o.d_done = ddn; o.d_rdata = drd; o.d_stall = dst; o.err = 1'b0;
    return o;
  endfunction

  function automatic out_t cur();
    out_t o;
    o.mem_en = mem_en; o.mem_wr = mem_wr; o.mem_addr = mem_addr; o.mem_wdata = mem_wdata;
    o.i_done = i_done; o.i_rdata = i_rdata; o.i_stall = i_stall;
    o.d_done = d_done; o.d_rdata = d_rdata; o.d_stall = d_stall; o.err = err;
    return o;
  endfunction

  task automatic apply(input in_t v);
    i_req = v.i_req; i_addr = v.i_addr; i_cancel = v.i_cancel;
    d_req = v.d_req; d_wr = v.d_wr; d_addr = v.d_addr; d_wdata = v.d_wdata;
    mem_stall = v.mem_stall; mem_done = v.mem_done; mem_rdata = v.mem_rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Lone fetch, then simultaneous store+fetch, then a lone load, then stray mem_done.
    vecs[0]  = '{vi(1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0)};
    vecs[1]  = '{vi(1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0)};
    vecs[2]  = '{vi(1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234), vo(0, 0, 16'h0040, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0)};
    vecs[3]  = '{vi(1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(0, 0, 16'h0040, 16'h0000, 1, 16'h1234, 0, 0, 16'h0000, 0)};
    vecs[4]  = '{vi(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(0, 0, 16'h0040, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0)};
    vecs[5]  = '{vi(1, 16'h0080, 0, 1, 1, 16'h0100, 16'hBEEF, 0, 0, 16'h0000), vo(0, 0, 16'h0040, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1)};
    vecs[6]  = '{vi(1, 16'h0080, 0, 1, 1, 16'h0100, 16'hBEEF, 0, 0, 16'h0000), vo(1, 1, 16'h0100, 16'hBEEF, 0, 16'h0000, 1, 0, 16'h0000, 1)};
    vecs[7]  = '{vi(1, 16'h0080, 0, 1, 1, 16'h0100, 16'hBEEF, 0, 1, 16'h5555), vo(0, 1, 16'h0100, 16'hBEEF, 0, 16'h0000, 1, 0, 16'h0000, 1)};
    vecs[8]  = '{vi(1, 16'h0080, 0, 1, 1, 16'h0100, 16'hBEEF, 0, 0, 16'h0000), vo(0, 1, 16'h0100, 16'hBEEF, 0, 16'h0000, 1, 1, 16'h0000, 0)};
    vecs[9]  = '{vi(1, 16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(1, 0, 16'h0080, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0)};
    vecs[10] = '{vi(1, 16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hABCD), vo(0, 0, 16'h0080, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0)};
    vecs[11] = '{vi(1, 16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(0, 0, 16'h0080, 16'h0000, 1, 16'hABCD, 0, 0, 16'h0000, 0)};
    vecs[12] = '{vi(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(0, 0, 16'h0080, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0)};
    vecs[13] = '{vi(0, 16'h0000, 0, 1, 0, 16'h0200, 16'h1111, 0, 0, 16'h0000), vo(0, 0, 16'h0080, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1)};
    vecs[14] = '{vi(0, 16'h0000, 0, 1, 0, 16'h0200, 16'h1111, 0, 0, 16'h0000), vo(1, 0, 16'h0200, 16'h1111, 0, 16'h0000, 0, 0, 16'h0000, 1)};
    vecs[15] = '{vi(0, 16'h0000, 0, 1, 0, 16'h0200, 16'h1111, 0, 1, 16'h7777), vo(0, 0, 16'h0200, 16'h1111, 0, 16'h0000, 0, 0, 16'h0000, 1)};
    vecs[16] = '{vi(0, 16'h0000, 0, 1, 0, 16'h0200, 16'h1111, 0, 0, 16'h0000), vo(0, 0, 16'h0200, 16'h1111, 0, 16'h0000, 0, 1, 16'h7777, 0)};
    vecs[17] = '{vi(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(0, 0, 16'h0200, 16'h1111, 0, 16'h0000, 0, 0, 16'h0000, 0)};
    vecs[18] = '{vi(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h4242), vo(0, 0, 16'h0200, 16'h1111, 0, 16'h0000, 0, 0, 16'h0000, 0)};
    vecs[19] = '{vi(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000), vo(0, 0, 16'h0200, 16'h1111, 0, 16'h0000, 0, 0, 16'h0000, 0)};

    rst = 1'b1;
    apply(vi(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", cur(), vo(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0));
    chk("reset_state", dut.state, ARB_IDLE);
    chk("reset_starve", dut.u_starve.count, 0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      apply(vecs[k].in);
      #1;
      chk($sformatf("vec%0d", k), cur(), vecs[k].exp);
      step();
    end

    // Memory holds off acceptance for three cycles.
    apply(vi(1, 16'h0300, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000));
    #1;
    chk("stall_req_istall", i_stall, 1);
    step();
    for (int b = 0; b < 4; b++) begin
      mem_stall = (b < 3);
      #1;
      chk($sformatf("stall_hold_en%0d", b), mem_en, 1);
      chk($sformatf("stall_hold_addr%0d", b), mem_addr, 16'h0300);
      step();
    end
    chk("stall_accept_state", dut.state, ARB_WAIT);
    mem_done = 1'b1; mem_rdata = 16'h0F0F;
    step();
    mem_done = 1'b0;
    #1;
    chk("stall_idone", i_done, 1);
    chk("stall_irdata", i_rdata, 16'h0F0F);
    i_req = 1'b0;
    step();

    // Fetch squashed while waiting; the pending load goes next.
    apply(vi(1, 16'h0400, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
    step();
    step();
    i_cancel = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
    #1;
    chk("cancel_istall_low", i_stall, 0);
    chk("cancel_in_wait", dut.state, ARB_WAIT);
    step();
    i_cancel = 1'b0; i_req = 1'b0; mem_done = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_done = 1'b0;
    #1;
    chk("cancel_no_idone", i_done, 0);
    chk("cancel_back_idle", dut.state, ARB_IDLE);
    step();
    chk("cancel_d_issue_en", mem_en, 1);
    chk("cancel_d_issue_addr", mem_addr, 16'h0500);
    chk("cancel_d_issue_wr", mem_wr, 0);
    step();
    mem_done = 1'b1; mem_rdata = 16'h2468;
    step();
    mem_done = 1'b0;
    #1;
    chk("cancel_d_done", d_done, 1);
    chk("cancel_d_rdata", d_rdata, 16'h2468);
    d_req = 1'b0;
    step();

    // Back-to-back stores against a persistent fetch; fetch re-arbitrates after a squash.
    apply(vi(1, 16'h0600, 0, 1, 1, 16'h0700, 16'hA000, 0, 0, 16'h0000));
    for (int r = 0; r < 4; r++) begin
      d_addr = 16'h0700 + 16'(r); d_wdata = 16'hA000 + 16'(r);
      step();
      chk($sformatf("starve_r%0d_d_won", r), mem_wr, 1);
      chk($sformatf("starve_r%0d_addr", r), mem_addr, 16'h0700 + 16'(r));
      chk($sformatf("starve_r%0d_count", r), dut.u_starve.count, r + 1);
      step();
      mem_done = 1'b1;
      step();
      mem_done = 1'b0; i_cancel = 1'b1;
      #1;
      chk($sformatf("starve_r%0d_ddone", r), d_done, 1);
      chk($sformatf("starve_r%0d_drdata", r), d_rdata, 16'h0000);
      step();
      i_cancel = 1'b0;
    end
    step();
    chk("starve_i_wins_addr", mem_addr, 16'h0600);
    chk("starve_i_wins_wr", mem_wr, 0);
    chk("starve_count_clr", dut.u_starve.count, 0);
    step();
    mem_done = 1'b1; mem_rdata = 16'h3333;
    step();
    mem_done = 1'b0;
    #1;
    chk("starve_idone", i_done, 1);
    chk("starve_irdata", i_rdata, 16'h3333);
    i_req = 1'b0;
    step();
    step();
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    #1;
    chk("starve_last_ddone", d_done, 1);
    d_req = 1'b0;
    step();

    // mem_done arriving on the last allowed wait cycle wins over the timeout.
    apply(vi(1, 16'h0900, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
    step();
    step();
    repeat (7) step();
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    #1;
    chk("edge_still_wait", dut.state, ARB_WAIT);
    step();
    mem_done = 1'b0;
    #1;
    chk("edge_no_err", err, 0);
    chk("edge_idone", i_done, 1);
    chk("edge_irdata", i_rdata, 16'h5A5A);
    i_req = 1'b0;
    step();

    // Hung memory: eight wait cycles then sticky error until reset.
    apply(vi(1, 16'h0800, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
    step();
    step();
    for (int w = 0; w < 8; w++) begin
      chk($sformatf("to_wait%0d_err", w), err, 0);
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    #1;
    chk("to_err_set", err, 1);
    chk("to_state_err", dut.state, ARB_ERR);
    chk("to_istall_forced", i_stall, 1);
    chk("to_dstall_forced", d_stall, 1);
    chk("to_mem_en_low", mem_en, 0);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    #1;
    chk("to_no_done_in_err", {i_done, d_done}, 2'b00);
    chk("to_err_sticky", err, 1);
    rst = 1'b1;
    #1;
    chk("to_rst_err_clr", err, 0);
    chk("to_rst_idle", dut.state, ARB_IDLE);
    step();
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
